// File: rtl/shift_engine_pkg.sv
// Shared types and helpers for the shift engine and its framing counter.
package shift_engine_pkg;

    typedef enum logic {
        STATE_IDLE   = 1'b0,
        STATE_ACTIVE = 1'b1
    } state_e;

    // Counter width for a given modulus; never narrower than one bit.
    function automatic int unsigned count_width(input int unsigned modulus);
        return (modulus < 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/shift_engine_if.sv
// Serial/parallel bus between the shift engine and its neighbours.
interface shift_engine_if #(
    parameter int unsigned width = 8
);
    logic             sampleEdge;
    logic             launchEdge;
    logic             csActive;
    logic             parallelLoad;
    logic [width-1:0] parallelDataIn;
    logic             serialDataIn;
    logic [width-1:0] parallelDataOut;
    logic             serialDataOut;
    logic             wordValid;
    logic             loadReject;
    logic             busy;

    modport master (
        output sampleEdge, launchEdge, csActive, parallelLoad,
               parallelDataIn, serialDataIn,
        input  parallelDataOut, serialDataOut, wordValid, loadReject, busy
    );

    modport slave (
        input  sampleEdge, launchEdge, csActive, parallelLoad,
               parallelDataIn, serialDataIn,
        output parallelDataOut, serialDataOut, wordValid, loadReject, busy
    );
endinterface

// File: rtl/shift_engine_bit_counter.sv
// Modulus counter with synchronous clear, enable and a wrap pulse
// flagged in the cycle the counter rolls from MODULUS-1 back to 0.
module shift_engine_bit_counter #(
    parameter int unsigned MODULUS = 8,
    parameter int unsigned CW      = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_enable,
    output logic [CW-1:0] o_count,
    output logic          o_wrap_c
);
    localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

    logic [CW-1:0] r_count;

    assign o_count  = r_count;
    assign o_wrap_c = i_enable && !i_clear && (r_count == LAST);

    // Count enabled events; explicit wrap so non-power-of-two moduli work.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
        end
    end
endmodule

// File: rtl/shift_engine.sv
// Chip-select framed serial/parallel shift engine (SPI mode 0) with a
// receive holding register, word strobe and load-reject reporting.
module shift_engine
    import shift_engine_pkg::*;
#(
    parameter int unsigned width    = 8,
    parameter bit          lsbFirst = 1'b0
) (
    input logic           clk,
    input logic           reset,
    shift_engine_if.slave bus
);
    localparam int unsigned CW = count_width(width);

    state_e           r_state;
    state_e           w_state_next;
    logic [CW-1:0]    w_count;
    logic             w_wrap_c;
    logic             w_frame;
    logic             w_sample;
    logic             w_launch;
    logic             w_load_ok;
    logic             w_load_rej;
    logic             w_clear;
    logic [width-1:0] w_shifted;
    logic             w_exit;
    logic             w_load_exit;

    logic [width-1:0] r_shift;
    logic [width-1:0] r_pdo;
    logic             r_sdo;
    logic             r_word_valid;
    logic             r_load_reject;
    logic             r_busy;

    // Edges count only inside an established frame; the cs-rise cycle is excluded.
    assign w_frame    = (r_state == STATE_ACTIVE) && bus.csActive;
    assign w_sample   = w_frame && bus.sampleEdge;
    assign w_launch   = w_frame && bus.launchEdge && !bus.sampleEdge;
    assign w_load_ok  = bus.parallelLoad && (w_count == '0) && !bus.sampleEdge;
    assign w_load_rej = bus.parallelLoad && !w_load_ok;
    assign w_clear    = !bus.csActive;

    if (lsbFirst) begin : g_lsb_first
        assign w_shifted   = {bus.serialDataIn, r_shift[width-1:1]};
        assign w_exit      = r_shift[0];
        assign w_load_exit = bus.parallelDataIn[0];
    end else begin : g_msb_first
        assign w_shifted   = {r_shift[width-2:0], bus.serialDataIn};
        assign w_exit      = r_shift[width-1];
        assign w_load_exit = bus.parallelDataIn[width-1];
    end

    shift_engine_bit_counter #(
        .MODULUS (width),
        .CW      (CW)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_enable (w_sample),
        .o_count  (w_count),
        .o_wrap_c (w_wrap_c)
    );

    // Frame state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= STATE_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame next-state: follow the sampled chip select one clock later.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            STATE_IDLE:   if (bus.csActive)  w_state_next = STATE_ACTIVE;
            STATE_ACTIVE: if (!bus.csActive) w_state_next = STATE_IDLE;
        endcase
    end

    // Shift datapath, holding register and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift       <= '0;
            r_pdo         <= '0;
            r_sdo         <= 1'b0;
            r_word_valid  <= 1'b0;
            r_load_reject <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_word_valid  <= w_wrap_c;
            r_load_reject <= w_load_rej;

            if (w_load_ok) begin
                r_shift <= bus.parallelDataIn;
            end else if (w_sample) begin
                r_shift <= w_shifted;
            end

            if (w_wrap_c) begin
                r_pdo <= w_shifted;
            end

            if (w_load_ok) begin
                r_sdo <= w_load_exit;
            end else if (w_launch) begin
                r_sdo <= w_exit;
            end

            if (w_clear) begin
                r_busy <= 1'b0;
            end else if (w_sample) begin
                r_busy <= !w_wrap_c;
            end
        end
    end

    assign bus.parallelDataOut = r_pdo;
    assign bus.serialDataOut   = r_sdo;
    assign bus.wordValid       = r_word_valid;
    assign bus.loadReject      = r_load_reject;
    assign bus.busy            = r_busy;
endmodule

// File: tb/tb_shift_engine.sv
// Scoreboard bench: an 8-bit MSB-first engine and a 12-bit LSB-first engine.
module tb_shift_engine;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    shift_engine_if #(.width(8))  a_if ();
    shift_engine_if #(.width(12)) b_if ();

    shift_engine #(.width(8), .lsbFirst(1'b0)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    shift_engine #(.width(12), .lsbFirst(1'b1)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  q_a [$];
    logic [11:0] q_b [$];

    // Hand-computed serial sequences.
    logic rx_a6 [8]  = '{1, 0, 1, 0, 0, 1, 1, 0};
    logic tx_c3 [8]  = '{1, 1, 0, 0, 0, 0, 1, 1};
    logic rx_b3 [6]  = '{1, 1, 0, 0, 1, 1};
    logic rx_3c [8]  = '{0, 0, 1, 1, 1, 1, 0, 0};
    logic tx_5a3[12] = '{1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0};
    logic rx_f0f[12] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic a_sample(input logic b);
        a_if.sampleEdge   = 1'b1;
        a_if.serialDataIn = b;
        tick();
        a_if.sampleEdge   = 1'b0;
    endtask

    task automatic a_launch;
        a_if.launchEdge = 1'b1;
        tick();
        a_if.launchEdge = 1'b0;
    endtask

    task automatic a_load(input logic [7:0] d);
        a_if.parallelLoad   = 1'b1;
        a_if.parallelDataIn = d;
        tick();
        a_if.parallelLoad   = 1'b0;
    endtask

    task automatic a_check_zero(input string tag);
        check({tag, "_pdo"},  32'(a_if.parallelDataOut), 32'h0);
        check({tag, "_sdo"},  32'(a_if.serialDataOut),   32'h0);
        check({tag, "_wv"},   32'(a_if.wordValid),       32'h0);
        check({tag, "_rej"},  32'(a_if.loadReject),      32'h0);
        check({tag, "_busy"}, 32'(a_if.busy),            32'h0);
    endtask

    // Monitor for the 8-bit engine: every word strobe consumes one expectation.
    always @(negedge clk) begin : mon_a
        logic [7:0] e;
        if (a_if.wordValid === 1'b1) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL a_word: actual=%0h required=no word", a_if.parallelDataOut);
            end else begin
                e = q_a.pop_front();
                if (a_if.parallelDataOut !== e) begin
                    errors++;
                    $display("FAIL a_word: actual=%0h required=%0h", a_if.parallelDataOut, e);
                end
            end
        end
    end

    // Monitor for the 12-bit engine.
    always @(negedge clk) begin : mon_b
        logic [11:0] e;
        if (b_if.wordValid === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL b_word: actual=%0h required=no word", b_if.parallelDataOut);
            end else begin
                e = q_b.pop_front();
                if (b_if.parallelDataOut !== e) begin
                    errors++;
                    $display("FAIL b_word: actual=%0h required=%0h", b_if.parallelDataOut, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        a_if.sampleEdge = 1'b0; a_if.launchEdge = 1'b0; a_if.csActive = 1'b0;
        a_if.parallelLoad = 1'b0; a_if.parallelDataIn = '0; a_if.serialDataIn = 1'b0;
        b_if.sampleEdge = 1'b0; b_if.launchEdge = 1'b0; b_if.csActive = 1'b0;
        b_if.parallelLoad = 1'b0; b_if.parallelDataIn = '0; b_if.serialDataIn = 1'b0;
        tick();
        tick();
        a_check_zero("reset");
        check("reset_b_busy", 32'(b_if.busy), 32'h0);
        reset = 1'b0;

        // MSB-first receive of 0xA6; an edge on the cs-rise cycle is ignored.
        a_if.csActive     = 1'b1;
        a_if.sampleEdge   = 1'b1;
        a_if.serialDataIn = 1'b1;
        tick();
        a_if.sampleEdge   = 1'b0;
        check("cs_rise_edge_ignored", 32'(a_if.busy), 32'h0);
        q_a.push_back(8'hA6);
        for (int i = 0; i < 8; i++) begin
            a_sample(rx_a6[i]);
            if (i == 0) check("busy_rise", 32'(a_if.busy), 32'h1);
            if (i < 7)  check("wv_early", 32'(a_if.wordValid), 32'h0);
        end
        check("wv_latency", 32'(a_if.wordValid), 32'h1);
        check("busy_fall", 32'(a_if.busy), 32'h0);
        check("pdo_a6", 32'(a_if.parallelDataOut), 32'hA6);
        tick();
        check("wv_single", 32'(a_if.wordValid), 32'h0);

        // MSB-first loopback of 0xC3.
        a_load(8'hC3);
        check("load_c3_rej", 32'(a_if.loadReject), 32'h0);
        check("tx_c3_bit0", 32'(a_if.serialDataOut), 32'(tx_c3[0]));
        q_a.push_back(8'hC3);
        for (int i = 0; i < 8; i++) begin
            a_sample(a_if.serialDataOut);
            if (i < 7) begin
                a_launch();
                check("tx_c3_bit", 32'(a_if.serialDataOut), 32'(tx_c3[i+1]));
            end
        end
        tick();

        // Reject mid-word load, then abort the frame after five samples.
        a_load(8'h55);
        check("load_55_rej", 32'(a_if.loadReject), 32'h0);
        for (int i = 0; i < 3; i++) a_sample(1'b0);
        a_load(8'h00);
        check("reject_pulse", 32'(a_if.loadReject), 32'h1);
        tick();
        check("reject_single", 32'(a_if.loadReject), 32'h0);
        a_launch();
        check("reject_keeps_shift", 32'(a_if.serialDataOut), 32'h1);
        for (int i = 0; i < 2; i++) a_sample(1'b0);
        check("busy_mid", 32'(a_if.busy), 32'h1);
        a_if.csActive     = 1'b0;
        a_if.sampleEdge   = 1'b1;
        a_if.serialDataIn = 1'b1;
        tick();
        a_if.sampleEdge   = 1'b0;
        check("abort_busy", 32'(a_if.busy), 32'h0);
        check("abort_wv", 32'(a_if.wordValid), 32'h0);
        check("abort_pdo", 32'(a_if.parallelDataOut), 32'hC3);
        tick();
        check("abort_wv_after", 32'(a_if.wordValid), 32'h0);

        // Simultaneous events: load+sample rejected, sample beats launch.
        a_if.csActive = 1'b1;
        tick();
        q_a.push_back(8'hB3);
        a_if.parallelLoad   = 1'b1;
        a_if.parallelDataIn = 8'h00;
        a_if.sampleEdge     = 1'b1;
        a_if.serialDataIn   = 1'b1;
        tick();
        a_if.parallelLoad   = 1'b0;
        a_if.sampleEdge     = 1'b0;
        check("load_sample_rej", 32'(a_if.loadReject), 32'h1);
        check("load_sample_sdo", 32'(a_if.serialDataOut), 32'h1);
        a_if.sampleEdge   = 1'b1;
        a_if.launchEdge   = 1'b1;
        a_if.serialDataIn = 1'b0;
        tick();
        a_if.sampleEdge   = 1'b0;
        a_if.launchEdge   = 1'b0;
        check("sample_beats_launch", 32'(a_if.serialDataOut), 32'h1);
        for (int i = 0; i < 6; i++) a_sample(rx_b3[i]);
        tick();

        // Reset mid-word, then a clean word.
        for (int i = 0; i < 3; i++) a_sample(1'b1);
        check("busy_pre_reset", 32'(a_if.busy), 32'h1);
        reset = 1'b1;
        tick();
        a_check_zero("midreset");
        reset = 1'b0;
        tick();
        q_a.push_back(8'h3C);
        for (int i = 0; i < 8; i++) a_sample(rx_3c[i]);
        check("pdo_3c", 32'(a_if.parallelDataOut), 32'h3C);
        tick();

        // LSB-first, 12-bit: transmit 0x5A3 while receiving 0xF0F.
        b_if.csActive = 1'b1;
        tick();
        b_if.parallelLoad   = 1'b1;
        b_if.parallelDataIn = 12'h5A3;
        tick();
        b_if.parallelLoad   = 1'b0;
        check("tx_5a3_bit0", 32'(b_if.serialDataOut), 32'(tx_5a3[0]));
        q_b.push_back(12'hF0F);
        for (int i = 0; i < 12; i++) begin
            b_if.sampleEdge   = 1'b1;
            b_if.serialDataIn = rx_f0f[i];
            tick();
            b_if.sampleEdge   = 1'b0;
            if (i < 11) begin
                b_if.launchEdge = 1'b1;
                tick();
                b_if.launchEdge = 1'b0;
                check("tx_5a3_bit", 32'(b_if.serialDataOut), 32'(tx_5a3[i+1]));
            end
        end
        check("b_wv_latency", 32'(b_if.wordValid), 32'h1);
        tick();
        tick();

        check("a_queue_drained", 32'(q_a.size()), 32'h0);
        check("b_queue_drained", 32'(q_b.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
